// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction buffer: compacts up to 4 valid slots per cycle, presents the oldest 2.
// Entries visible on out_* one cycle after enqueue; in_ready drops unless 4 free entries remain.
module fetch_queue #(
  parameter int DEPTH = 16,
  parameter int XLEN  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [XLEN-1:0]          in_instr1,
  input  logic [XLEN-1:0]          in_instr2,
  input  logic [XLEN-1:0]          in_instr3,
  input  logic [XLEN-1:0]          in_instr4,
  input  logic [XLEN-1:0]          in_target1,
  input  logic [XLEN-1:0]          in_target2,
  input  logic [XLEN-1:0]          in_target3,
  input  logic [XLEN-1:0]          in_target4,
  input  logic                     in_taken1,
  input  logic                     in_taken2,
  input  logic                     in_taken3,
  input  logic                     in_taken4,
  input  logic                     in_valid1,
  input  logic                     in_valid2,
  input  logic                     in_valid3,
  input  logic                     in_valid4,
  output logic                     in_ready,
  output logic                     fetch_stall,
  input  logic                     flush,
  output logic [XLEN-1:0]          out_instr1,
  output logic [XLEN-1:0]          out_instr2,
  output logic [XLEN-1:0]          out_target1,
  output logic [XLEN-1:0]          out_target2,
  output logic                     out_taken1,
  output logic                     out_taken2,
  output logic                     out_valid1,
  output logic                     out_valid2,
  input  logic                     dec_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0]  r_instr  [DEPTH];
  logic [XLEN-1:0]  r_target [DEPTH];
  logic [DEPTH-1:0] r_taken;
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [CW-1:0]    r_count;

  logic [XLEN-1:0]  w_slot_instr  [4];
  logic [XLEN-1:0]  w_slot_target [4];
  logic [3:0]       w_slot_taken;
  logic [3:0]       w_slot_vld;
  logic [2:0]       w_off [4];
  logic [2:0]       w_n_enq;
  logic [1:0]       w_n_deq;
  logic             w_enq;
  logic [CW-1:0]    w_count_nxt;
  logic [AW-1:0]    w_rd2;

  assign w_slot_instr[0]  = in_instr1;
  assign w_slot_instr[1]  = in_instr2;
  assign w_slot_instr[2]  = in_instr3;
  assign w_slot_instr[3]  = in_instr4;
  assign w_slot_target[0] = in_target1;
  assign w_slot_target[1] = in_target2;
  assign w_slot_target[2] = in_target3;
  assign w_slot_target[3] = in_target4;
  assign w_slot_taken     = {in_taken4, in_taken3, in_taken2, in_taken1};
  assign w_slot_vld       = {in_valid4, in_valid3, in_valid2, in_valid1};

  // Each valid slot lands at tail + (number of valid older slots), squeezing out holes.
  assign w_off[0] = 3'd0;
  assign w_off[1] = 3'(w_slot_vld[0]);
  assign w_off[2] = 3'(w_slot_vld[0]) + 3'(w_slot_vld[1]);
  assign w_off[3] = 3'(w_slot_vld[0]) + 3'(w_slot_vld[1]) + 3'(w_slot_vld[2]);
  assign w_n_enq  = w_off[3] + 3'(w_slot_vld[3]);

  assign in_ready    = (r_count <= CW'(DEPTH - 4));
  assign fetch_stall = !in_ready;
  assign w_enq       = in_ready && (w_slot_vld != 4'd0);
  assign w_n_deq     = !dec_ready            ? 2'd0 :
                       (r_count >= CW'(2))   ? 2'd2 : r_count[1:0];
  assign w_count_nxt = r_count + (w_enq ? CW'(w_n_enq) : CW'(0)) - CW'(w_n_deq);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_taken <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_instr[i]  <= '0;
        r_target[i] <= '0;
      end
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        for (int k = 0; k < 4; k++) begin
          if (w_slot_vld[k]) begin
            r_instr[r_tail + AW'(w_off[k])]  <= w_slot_instr[k];
            r_target[r_tail + AW'(w_off[k])] <= w_slot_target[k];
            r_taken[r_tail + AW'(w_off[k])]  <= w_slot_taken[k];
          end
        end
        r_tail <= r_tail + AW'(w_n_enq);
      end
      r_head  <= r_head + AW'(w_n_deq);
      r_count <= w_count_nxt;
    end
  end

  assign w_rd2       = r_head + AW'(1);
  assign out_instr1  = r_instr[r_head];
  assign out_instr2  = r_instr[w_rd2];
  assign out_target1 = r_target[r_head];
  assign out_target2 = r_target[w_rd2];
  assign out_taken1  = r_taken[r_head];
  assign out_taken2  = r_taken[w_rd2];
  assign out_valid1  = (r_count != CW'(0));
  assign out_valid2  = (r_count >= CW'(2));
  assign count       = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: table-driven vectors on a 16-deep instance, hand sequences on an 8-deep one.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] i1, i2, i3, i4, t1, t2, t3, t4;
  logic        k1, k2, k3, k4, v1, v2, v3, v4;
  logic        flush, dec_ready;

  logic        rdy16, stall16, ov1_16, ov2_16, ok1_16, ok2_16;
  logic [63:0] oi1_16, oi2_16, ot1_16, ot2_16;
  logic [4:0]  cnt16;
  logic        rdy8, stall8, ov1_8, ov2_8, ok1_8, ok2_8;
  logic [63:0] oi1_8, oi2_8, ot1_8, ot2_8;
  logic [3:0]  cnt8;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(16), .XLEN(64)) u_q16 (
    .clk(clk), .rst(rst),
    .in_instr1(i1), .in_instr2(i2), .in_instr3(i3), .in_instr4(i4),
    .in_target1(t1), .in_target2(t2), .in_target3(t3), .in_target4(t4),
    .in_taken1(k1), .in_taken2(k2), .in_taken3(k3), .in_taken4(k4),
    .in_valid1(v1), .in_valid2(v2), .in_valid3(v3), .in_valid4(v4),
    .in_ready(rdy16), .fetch_stall(stall16), .flush(flush),
    .out_instr1(oi1_16), .out_instr2(oi2_16), .out_target1(ot1_16), .out_target2(ot2_16),
    .out_taken1(ok1_16), .out_taken2(ok2_16), .out_valid1(ov1_16), .out_valid2(ov2_16),
    .dec_ready(dec_ready), .count(cnt16)
  );

  fetch_queue #(.DEPTH(8), .XLEN(64)) u_q8 (
    .clk(clk), .rst(rst),
    .in_instr1(i1), .in_instr2(i2), .in_instr3(i3), .in_instr4(i4),
    .in_target1(t1), .in_target2(t2), .in_target3(t3), .in_target4(t4),
    .in_taken1(k1), .in_taken2(k2), .in_taken3(k3), .in_taken4(k4),
    .in_valid1(v1), .in_valid2(v2), .in_valid3(v3), .in_valid4(v4),
    .in_ready(rdy8), .fetch_stall(stall8), .flush(flush),
    .out_instr1(oi1_8), .out_instr2(oi2_8), .out_target1(ot1_8), .out_target2(ot2_8),
    .out_taken1(ok1_8), .out_taken2(ok2_8), .out_valid1(ov1_8), .out_valid2(ov2_8),
    .dec_ready(dec_ready), .count(cnt8)
  );

  typedef struct {
    int m, a, b, c, d, tk2, tg2, dec, fl;
    int e_cnt, e_v1, e_v2, e_rdy, e_o1, e_o2, e_tk1, e_tg1;
  } vec_t;

  vec_t        tbl [21];
  logic [63:0] mq [$];
  logic [63:0] vals [4];
  logic [3:0]  cur_m;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] m, input logic [63:0] a, b, c, d,
                       input logic tk2, input logic [63:0] tg2, input logic dec, input logic fl);
    {v4, v3, v2, v1} = m;
    i1 = a; i2 = b; i3 = c; i4 = d;
    t1 = '0; t2 = tg2; t3 = '0; t4 = '0;
    k1 = 1'b0; k2 = tk2; k3 = 1'b0; k4 = 1'b0;
    dec_ready = dec;
    flush = fl;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(4'h0, 0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic cmp8(input string nm);
    chk({nm, " cnt"}, 64'(cnt8), 64'(mq.size()));
    chk({nm, " v1"}, 64'(ov1_8), 64'(mq.size() >= 1));
    chk({nm, " v2"}, 64'(ov2_8), 64'(mq.size() >= 2));
    chk({nm, " bound"}, 64'(cnt8 <= 4'd8), 64'd1);
    if (mq.size() >= 1) chk({nm, " o1"}, oi1_8, mq[0]);
    if (mq.size() >= 2) chk({nm, " o2"}, oi2_8, mq[1]);
  endtask

  initial begin
    //           m     a      b      c      d     tk2 tg2     dec fl  cnt v1 v2 rdy o1     o2    tk1 tg1
    tbl[0]  = '{'hF, 'h11,  'h22,  'h33,  'h44,  0, 0,       0, 0,  4, 1, 1, 1, 'h11,  'h22, 0, 0};
    tbl[1]  = '{'h0, 0,     0,     0,     0,     0, 0,       0, 1,  0, 0, 0, 1, 0,     0,    0, 0};
    tbl[2]  = '{'hA, 'hA,   'hB,   'hC,   'hD,   1, 'h1000,  0, 0,  2, 1, 1, 1, 'hB,   'hD,  1, 'h1000};
    tbl[3]  = '{'h0, 0,     0,     0,     0,     0, 0,       1, 0,  0, 0, 0, 1, 0,     0,    0, 0};
    tbl[4]  = '{'h7, 'h21,  'h22,  'h23,  'h24,  0, 0,       0, 0,  3, 1, 1, 1, 'h21,  'h22, 0, 0};
    tbl[5]  = '{'hF, 'h31,  'h32,  'h33,  'h34,  0, 0,       1, 0,  5, 1, 1, 1, 'h23,  'h31, 0, 0};
    tbl[6]  = '{'h0, 0,     0,     0,     0,     0, 0,       1, 0,  3, 1, 1, 1, 'h32,  'h33, 0, 0};
    tbl[7]  = '{'h0, 0,     0,     0,     0,     0, 0,       1, 0,  1, 1, 0, 1, 'h34,  0,    0, 0};
    tbl[8]  = '{'h0, 0,     0,     0,     0,     0, 0,       1, 0,  0, 0, 0, 1, 0,     0,    0, 0};
    tbl[9]  = '{'h1, 'h41,  0,     0,     0,     0, 0,       1, 0,  1, 1, 0, 1, 'h41,  0,    0, 0};
    tbl[10] = '{'hF, 'h50,  'h51,  'h52,  'h53,  0, 0,       0, 0,  5, 1, 1, 1, 'h41,  'h50, 0, 0};
    tbl[11] = '{'hF, 'h54,  'h55,  'h56,  'h57,  0, 0,       0, 0,  9, 1, 1, 1, 'h41,  'h50, 0, 0};
    tbl[12] = '{'h1, 'h58,  0,     0,     0,     0, 0,       0, 0, 10, 1, 1, 1, 'h41,  'h50, 0, 0};
    tbl[13] = '{'hF, 'h60,  'h61,  'h62,  'h63,  0, 0,       1, 1,  0, 0, 0, 1, 0,     0,    0, 0};
    tbl[14] = '{'h1, 'h55,  0,     0,     0,     0, 0,       0, 0,  1, 1, 0, 1, 'h55,  0,    0, 0};
    tbl[15] = '{'hF, 'h70,  'h71,  'h72,  'h73,  0, 0,       0, 0,  5, 1, 1, 1, 'h55,  'h70, 0, 0};
    tbl[16] = '{'hF, 'h74,  'h75,  'h76,  'h77,  0, 0,       0, 0,  9, 1, 1, 1, 'h55,  'h70, 0, 0};
    tbl[17] = '{'hF, 'h78,  'h79,  'h7A,  'h7B,  0, 0,       0, 0, 13, 1, 1, 0, 'h55,  'h70, 0, 0};
    tbl[18] = '{'hF, 'h80,  'h81,  'h82,  'h83,  0, 0,       1, 0, 11, 1, 1, 1, 'h71,  'h72, 0, 0};
    tbl[19] = '{'h1, 'h90,  0,     0,     0,     0, 0,       0, 0, 12, 1, 1, 1, 'h71,  'h72, 0, 0};
    tbl[20] = '{'h1, 'h91,  0,     0,     0,     0, 0,       0, 0, 13, 1, 1, 0, 'h71,  'h72, 0, 0};

    do_reset();
    chk("reset cnt", 64'(cnt16), 64'd0);
    chk("reset v1", 64'(ov1_16), 64'd0);
    chk("reset v2", 64'(ov2_16), 64'd0);
    chk("reset rdy", 64'(rdy16), 64'd1);
    chk("reset stall", 64'(stall16), 64'd0);
    chk("reset instr1", oi1_16, 64'd0);
    chk("reset instr2", oi2_16, 64'd0);
    chk("reset target1", ot1_16, 64'd0);
    chk("reset taken1", 64'(ok1_16), 64'd0);

    for (int r = 0; r < 21; r++) begin
      drive(4'(tbl[r].m), 64'(tbl[r].a), 64'(tbl[r].b), 64'(tbl[r].c), 64'(tbl[r].d),
            1'(tbl[r].tk2), 64'(tbl[r].tg2), 1'(tbl[r].dec), 1'(tbl[r].fl));
      step();
      chk($sformatf("row%0d cnt", r), 64'(cnt16), 64'(tbl[r].e_cnt));
      chk($sformatf("row%0d v1", r), 64'(ov1_16), 64'(tbl[r].e_v1));
      chk($sformatf("row%0d v2", r), 64'(ov2_16), 64'(tbl[r].e_v2));
      chk($sformatf("row%0d rdy", r), 64'(rdy16), 64'(tbl[r].e_rdy));
      chk($sformatf("row%0d stall", r), 64'(stall16), 64'(tbl[r].e_rdy == 0));
      if (tbl[r].e_v1 != 0) begin
        chk($sformatf("row%0d o1", r), oi1_16, 64'(tbl[r].e_o1));
        chk($sformatf("row%0d tk1", r), 64'(ok1_16), 64'(tbl[r].e_tk1));
        chk($sformatf("row%0d tg1", r), ot1_16, 64'(tbl[r].e_tg1));
      end
      if (tbl[r].e_v2 != 0) chk($sformatf("row%0d o2", r), oi2_16, 64'(tbl[r].e_o2));
    end

    // Backpressure on the 8-deep queue: a held third group must not slip in.
    do_reset();
    drive(4'hF, 'h101, 'h102, 'h103, 'h104, 1'b0, 0, 1'b0, 1'b0);
    step();
    chk("bp g1 cnt", 64'(cnt8), 64'd4);
    chk("bp g1 rdy", 64'(rdy8), 64'd1);
    drive(4'hF, 'h105, 'h106, 'h107, 'h108, 1'b0, 0, 1'b0, 1'b0);
    step();
    chk("bp full cnt", 64'(cnt8), 64'd8);
    chk("bp full rdy", 64'(rdy8), 64'd0);
    chk("bp full stall", 64'(stall8), 64'd1);
    drive(4'hF, 'h1F1, 'h1F2, 'h1F3, 'h1F4, 1'b0, 0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("bp hold%0d cnt", c), 64'(cnt8), 64'd8);
      chk($sformatf("bp hold%0d o1", c), oi1_8, 64'h101);
    end
    dec_ready = 1'b1;
    step();
    chk("bp drain1 cnt", 64'(cnt8), 64'd6);
    chk("bp drain1 rdy", 64'(rdy8), 64'd0);
    chk("bp drain1 o1", oi1_8, 64'h103);
    step();
    chk("bp drain2 cnt", 64'(cnt8), 64'd4);
    chk("bp drain2 rdy", 64'(rdy8), 64'd1);
    chk("bp drain2 o1", oi1_8, 64'h105);
    chk("bp drain2 o2", oi2_8, 64'h106);

    // Wrap-around stream against a reference FIFO, decode draining every cycle.
    do_reset();
    mq.delete();
    begin
      int  acc, cyc, id, ndq;
      bit  need_new, take;
      acc = 0; cyc = 0; id = 'h1000; need_new = 1'b1;
      while (acc < 20 && cyc < 300) begin
        if (need_new) begin
          cur_m = 4'($urandom_range(1, 15));
          for (int k = 0; k < 4; k++) vals[k] = 64'(id + k);
          id += 4;
          need_new = 1'b0;
        end
        drive(cur_m, vals[0], vals[1], vals[2], vals[3], 1'b0, 0, 1'b1, 1'b0);
        take = (mq.size() <= 4);
        ndq  = (mq.size() >= 2) ? 2 : mq.size();
        step();
        for (int k = 0; k < ndq; k++) void'(mq.pop_front());
        if (take) begin
          for (int k = 0; k < 4; k++) if (cur_m[k]) mq.push_back(vals[k]);
          acc++;
          need_new = 1'b1;
        end
        cmp8($sformatf("wrap c%0d", cyc));
        cyc++;
      end
      chk("wrap groups accepted", 64'(acc), 64'd20);
      drive(4'h0, 0, 0, 0, 0, 1'b0, 0, 1'b1, 1'b0);
      cyc = 0;
      while (mq.size() != 0 && cyc < 20) begin
        ndq = (mq.size() >= 2) ? 2 : mq.size();
        step();
        for (int k = 0; k < ndq; k++) void'(mq.pop_front());
        cmp8($sformatf("drain c%0d", cyc));
        cyc++;
      end
      chk("drain empty cnt", 64'(cnt8), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
